// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-bus responder.
// State encoding, I/O window offsets and the top of RAM.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [1:0] IO_LED  = 2'd0;
    localparam logic [1:0] IO_SW   = 2'd1;
    localparam logic [1:0] IO_CNT  = 2'd2;
    localparam logic [1:0] IO_STAT = 2'd3;

    localparam logic [7:0] RAM_TOP = 8'hEF;

endpackage

// File: rtl/mem_responder_if.sv
// Processor memory bus: request, address, data and response.
// The initiator holds a request until it sees ready.
interface mem_responder_if;

    logic       MemRead;
    logic       wren;
    logic [7:0] address;
    logic [7:0] data;
    logic [7:0] q;
    logic       ready;

    modport master (
        output MemRead, wren, address, data,
        input  q, ready
    );

    modport slave (
        input  MemRead, wren, address, data,
        output q, ready
    );

endinterface

// File: rtl/mem_io_regs.sv
// I/O window registers: LED latch, free-running counter,
// sticky error status, and the read mux for the window.
module mem_io_regs
    import mem_bus_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] sw_in,
    input  logic       led_we,
    input  logic [7:0] wdata,
    input  logic       set_err,
    input  logic [1:0] rd_off,
    output logic [7:0] led_out,
    output logic       err,
    output logic [7:0] rd_data
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led_out <= '0;
            err     <= 1'b0;
            cnt     <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
            if (led_we)
                led_out <= wdata;
            if (set_err)
                err <= 1'b1;
        end
    end

    always_comb begin
        rd_data = '0;
        unique case (rd_off)
            IO_LED:  rd_data = led_out;
            IO_SW:   rd_data = sw_in;
            IO_CNT:  rd_data = 8'(cnt);
            IO_STAT: rd_data = {7'b0, err};
            default: rd_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-bus responder: RAM below the I/O window, wait-state FSM,
// one-cycle ready pulse after each committed access.
module mem_responder
    import mem_bus_pkg::*;
#(
    parameter int         WAIT_CYCLES = 2,
    parameter logic [7:0] IO_BASE     = 8'hF0,
    parameter int         CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    mem_responder_if.slave   bus,
    input  logic [7:0]       sw_in,
    output logic [7:0]       led_out,
    output logic             err
);

    localparam logic [3:0] WAIT_M1 =
        (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t     state;
    logic [3:0] wcnt;
    logic [7:0] a_q;
    logic [7:0] d_q;
    logic       wr_q;
    logic [7:0] ram [0:RAM_TOP];

    logic       req;
    logic       go_resp;
    logic [7:0] cur_addr;
    logic [7:0] cur_data;
    logic       cur_wr;
    logic [7:0] io_off;
    logic       in_io;
    logic       in_ram;
    logic [7:0] io_rd;
    logic [7:0] rd_val;
    logic       ram_we;
    logic       led_we;
    logic       set_err;

    assign req = bus.MemRead | bus.wren;

    // With zero wait states the commit edge is the acceptance edge,
    // so the live bus values are used instead of the latched copy.
    assign cur_addr = (state == IDLE) ? bus.address : a_q;
    assign cur_data = (state == IDLE) ? bus.data    : d_q;
    assign cur_wr   = (state == IDLE) ? bus.wren    : wr_q;

    assign io_off = cur_addr - IO_BASE;
    assign in_io  = io_off < 8'd4;
    assign in_ram = (cur_addr <= RAM_TOP) && !in_io;

    always_comb begin
        go_resp = 1'b0;
        unique case (state)
            IDLE:    go_resp = req && (WAIT_CYCLES == 0);
            WAIT:    go_resp = req && (wcnt == 4'd0);
            default: go_resp = 1'b0;
        endcase
    end

    assign ram_we  = go_resp && cur_wr && in_ram && reset;
    assign led_we  = go_resp && cur_wr && in_io &&
                     (io_off[1:0] == IO_LED);
    assign set_err = (state == IDLE) && bus.MemRead && bus.wren;

    always_comb begin
        rd_val = '0;
        if (in_io)
            rd_val = io_rd;
        else if (in_ram)
            rd_val = ram[cur_addr];
    end

    mem_io_regs #(
        .CNT_W (CNT_W)
    ) u_io (
        .clock   (clock),
        .reset   (reset),
        .sw_in   (sw_in),
        .led_we  (led_we),
        .wdata   (cur_data),
        .set_err (set_err),
        .rd_off  (io_off[1:0]),
        .led_out (led_out),
        .err     (err),
        .rd_data (io_rd)
    );

    always_ff @(posedge clock) begin
        if (ram_we)
            ram[cur_addr] <= cur_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wcnt      <= '0;
            a_q       <= '0;
            d_q       <= '0;
            wr_q      <= 1'b0;
            bus.q     <= '0;
            bus.ready <= 1'b0;
        end else begin
            bus.ready <= 1'b0;
            if (go_resp && !cur_wr)
                bus.q <= rd_val;
            unique case (state)
                IDLE: if (req) begin
                    a_q   <= bus.address;
                    d_q   <= bus.data;
                    wr_q  <= bus.wren;
                    wcnt  <= WAIT_M1;
                    state <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
                WAIT: begin
                    if (!req)
                        state <= IDLE;
                    else if (wcnt == 4'd0)
                        state <= RESP;
                    else
                        wcnt <= wcnt - 4'd1;
                end
                RESP: begin
                    bus.ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: vector table, corner sequences,
// and randomized traffic against a simple memory-map model.
module tb_mem_responder;

    logic       clk;
    logic       rst2;
    logic       rst0;
    logic [7:0] sw2, sw0;
    logic [7:0] led2, led0;
    logic       err2, err0;

    mem_responder_if b2 ();
    mem_responder_if b0 ();

    mem_responder #(.WAIT_CYCLES(2)) u2 (
        .clock   (clk),
        .reset   (rst2),
        .bus     (b2.slave),
        .sw_in   (sw2),
        .led_out (led2),
        .err     (err2)
    );

    mem_responder #(.WAIT_CYCLES(0)) u0 (
        .clock   (clk),
        .reset   (rst0),
        .bus     (b0.slave),
        .sw_in   (sw0),
        .led_out (led0),
        .err     (err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // One transaction on the WAIT_CYCLES=2 instance; lat counts
    // falling edges from request until ready is seen.
    task automatic txn2(input bit rd, input bit wr,
                        input logic [7:0] a, input logic [7:0] d,
                        output int lat);
        @(negedge clk);
        b2.MemRead = rd;
        b2.wren    = wr;
        b2.address = a;
        b2.data    = d;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (b2.ready)
                break;
        end
        b2.MemRead = 1'b0;
        b2.wren    = 1'b0;
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] sw;
        bit         chk_q;
        logic [7:0] eq;
        bit         chk_led;
        logic [7:0] el;
    } vec_t;

    vec_t tbl [8];

    // Reference memory map
    logic [7:0] mem_m [256];
    bit         known [256];
    logic [7:0] led_m;
    bit         err_m;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit seen;
        int n, got;
        int rt [2];
        logic [7:0] qv [2];
        logic [7:0] qprev;

        b2.MemRead = 0; b2.wren = 0; b2.address = 0; b2.data = 0;
        b0.MemRead = 0; b0.wren = 0; b0.address = 0; b0.data = 0;
        sw2 = 8'h00; sw0 = 8'h00;
        rst2 = 1'b0; rst0 = 1'b0;

        #7;
        check("rst_ready", b2.ready, 0);
        check("rst_q", b2.q, 0);
        check("rst_led", led2, 0);
        check("rst_err", err2, 0);
        check("rst0_ready", b0.ready, 0);

        @(negedge clk);
        rst2 = 1'b1; rst0 = 1'b1;

        tbl[0] = '{1'b1, 8'h10, 8'h5A, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 8'h10, 8'h00, 8'h00, 1'b1, 8'h5A, 1'b0, 8'h00};
        tbl[2] = '{1'b1, 8'hF0, 8'h3C, 8'h00, 1'b0, 8'h00, 1'b1, 8'h3C};
        tbl[3] = '{1'b0, 8'hF1, 8'h00, 8'hA5, 1'b1, 8'hA5, 1'b1, 8'h3C};
        tbl[4] = '{1'b1, 8'hF1, 8'h00, 8'hA5, 1'b0, 8'h00, 1'b1, 8'h3C};
        tbl[5] = '{1'b0, 8'hF1, 8'h00, 8'hA5, 1'b1, 8'hA5, 1'b1, 8'h3C};
        tbl[6] = '{1'b1, 8'h20, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 8'h3C};
        tbl[7] = '{1'b0, 8'hF0, 8'h00, 8'h00, 1'b1, 8'h3C, 1'b1, 8'h3C};

        for (int i = 0; i < 8; i++) begin
            sw2 = tbl[i].sw;
            txn2(!tbl[i].wr, tbl[i].wr, tbl[i].a, tbl[i].d, lat);
            check($sformatf("vec%0d_lat", i), lat, 4);
            if (tbl[i].chk_q)
                check($sformatf("vec%0d_q", i), b2.q, tbl[i].eq);
            if (tbl[i].chk_led)
                check($sformatf("vec%0d_led", i), led2, tbl[i].el);
            @(negedge clk);
            check($sformatf("vec%0d_pulse", i), b2.ready, 0);
        end

        // Abort: write dropped one cycle after acceptance
        @(negedge clk);
        b2.wren = 1'b1; b2.address = 8'h20; b2.data = 8'h77;
        @(negedge clk);
        b2.wren = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (b2.ready) seen = 1'b1;
        end
        check("abort_noready", seen, 0);
        txn2(1, 0, 8'h20, 8'h00, lat);
        check("abort_q", b2.q, 8'h00);

        // Conflict: both requests, write wins, err sticks
        qprev = b2.q;
        txn2(1, 1, 8'h30, 8'h11, lat);
        check("conf_lat", lat, 4);
        check("conf_err", err2, 1);
        check("conf_qhold", b2.q, qprev);
        txn2(1, 0, 8'h30, 8'h00, lat);
        check("conf_ram", b2.q, 8'h11);
        txn2(1, 0, 8'hF3, 8'h00, lat);
        check("conf_stat", b2.q, 8'h01);

        // Randomized traffic around the RAM/I-O boundary
        for (int i = 0; i < 256; i++) known[i] = 1'b0;
        led_m = 8'h3C;
        err_m = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int sel;
            bit rd, wr;
            logic [7:0] a, d;
            sel = $urandom_range(0, 10);
            a = (sel < 8) ? 8'(8'hE8 + sel) :
                (sel == 8) ? 8'hF0 : (sel == 9) ? 8'hF1 : 8'hF3;
            d = 8'($urandom);
            wr = 1'($urandom);
            rd = !wr || ($urandom_range(0, 7) == 0);
            sw2 = 8'($urandom);
            txn2(rd, wr, a, d, lat);
            check($sformatf("rnd%0d_lat", i), lat, 4);
            if (wr) begin
                if (rd) err_m = 1'b1;
                if (a <= 8'hEF) begin
                    mem_m[a] = d;
                    known[a] = 1'b1;
                end else if (a == 8'hF0) begin
                    led_m = d;
                end
            end else if (a <= 8'hEF) begin
                if (known[a])
                    check($sformatf("rnd%0d_ram", i), b2.q, mem_m[a]);
            end else if (a == 8'hF0) begin
                check($sformatf("rnd%0d_led", i), b2.q, led_m);
            end else if (a == 8'hF1) begin
                check($sformatf("rnd%0d_sw", i), b2.q, sw2);
            end else begin
                check($sformatf("rnd%0d_st", i), b2.q, {7'b0, err_m});
            end
            check($sformatf("rnd%0d_ledpin", i), led2, led_m);
        end

        // Async reset mid-WAIT drops the pending write
        txn2(0, 1, 8'h40, 8'h12, lat);
        txn2(1, 0, 8'h10, 8'h00, lat);
        check("pre_rst_q", b2.q, 8'h5A);
        @(negedge clk);
        b2.wren = 1'b1; b2.address = 8'h40; b2.data = 8'h99;
        @(negedge clk);
        #2 rst2 = 1'b0;
        #1;
        check("arst_ready", b2.ready, 0);
        check("arst_q", b2.q, 0);
        check("arst_led", led2, 0);
        check("arst_err", err2, 0);
        b2.wren = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst2 = 1'b1;
        txn2(1, 0, 8'h40, 8'h00, lat);
        check("arst_ram", b2.q, 8'h12);

        // Zero wait states: held read of the counter
        @(negedge clk);
        b0.MemRead = 1'b1; b0.address = 8'hF2;
        n = 0; got = 0;
        rt[0] = 0; rt[1] = 0; qv[0] = 0; qv[1] = 0;
        while (got < 2 && n < 20) begin
            @(negedge clk);
            n++;
            if (b0.ready) begin
                rt[got] = n;
                qv[got] = b0.q;
                got++;
            end
        end
        b0.MemRead = 1'b0;
        check("w0_got", got, 2);
        check("w0_lat", rt[0], 2);
        check("w0_period", rt[1] - rt[0], 2);
        check("w0_delta", 8'(qv[1] - qv[0]), 8'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
